// File: rtl/psx_pkg.sv
// Shared constants, state encoding and byte helpers for the PSX pad responder.
package psx_pkg;

  localparam logic [7:0] PSX_CMD_START   = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL    = 8'h42;
  localparam logic [7:0] PSX_ID_DIGITAL  = 8'h41;
  localparam logic [7:0] PSX_READY       = 8'h5A;
  localparam int         PSX_FRAME_BYTES = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    ACK_WAIT  = 3'd2,
    ACK_PULSE = 3'd3,
    DONE      = 3'd4
  } psx_state_e;

  // Reply byte for a given position in the digital-pad poll frame.
  function automatic logic [7:0] psx_tx_byte(input logic [2:0] idx, input logic [15:0] btn);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hFF;
      3'd1:    b = PSX_ID_DIGITAL;
      3'd2:    b = PSX_READY;
      3'd3:    b = btn[7:0];
      default: b = btn[15:8];
    endcase
    return b;
  endfunction

  // Only the first two host bytes are checked; the rest are don't-care.
  function automatic logic psx_rx_ok(input logic [2:0] idx, input logic [7:0] rx);
    logic ok;
    case (idx)
      3'd0:    ok = (rx == PSX_CMD_START);
      3'd1:    ok = (rx == PSX_CMD_POLL);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchronizer with a one-cycle rise/fall detector. Idle level is high.
module psx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // Synchronize the pin and keep the previous synced value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_prev;
  assign o_fall  = ~r_s2 & r_prev;

endmodule

// File: rtl/psx_pad_responder.sv
// Controller-side responder for the PlayStation pad link (5-byte digital poll).
// All link pins are oversampled by clk; psx_clk is treated as data only.
module psx_pad_responder
  import psx_pkg::*;
#(
  parameter int ACK_DELAY = 4,
  parameter int ACK_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic        att,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack
);

  localparam int CNT_W_D = $clog2(ACK_DELAY + 1);
  localparam int CNT_W_W = $clog2(ACK_WIDTH + 1);
  localparam int CNT_W   = (CNT_W_D > CNT_W_W) ? CNT_W_D : CNT_W_W;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(ACK_DELAY - 1);
  localparam logic [CNT_W-1:0] WID_LAST = CNT_W'(ACK_WIDTH - 1);
  localparam logic [2:0]       LAST_IDX = 3'(PSX_FRAME_BYTES - 1);

  logic w_clk_lvl, w_clk_rise, w_clk_fall;
  logic w_cmd_lvl, w_cmd_rise, w_cmd_fall;
  logic w_att_lvl, w_att_rise, w_att_fall;
  logic w_unused_ok;

  psx_sync_edge u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .i_d     (psx_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  psx_sync_edge u_sync_cmd (
    .clk     (clk),
    .rst     (rst),
    .i_d     (cmd),
    .o_level (w_cmd_lvl),
    .o_rise  (w_cmd_rise),
    .o_fall  (w_cmd_fall)
  );

  psx_sync_edge u_sync_att (
    .clk     (clk),
    .rst     (rst),
    .i_d     (att),
    .o_level (w_att_lvl),
    .o_rise  (w_att_rise),
    .o_fall  (w_att_fall)
  );

  assign w_unused_ok = ^{w_clk_lvl, w_cmd_rise, w_cmd_fall};

  psx_state_e       r_state;
  logic [2:0]       r_byte_idx;
  logic [2:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_data;
  logic             r_ack;
  logic [1:0]       r_settle;
  logic             r_armed;
  logic [7:0]       r_rx;
  logic [15:0]      r_btn;

  logic [7:0]       w_tx_byte;
  logic [7:0]       w_rx_next;
  logic             w_rx_ok;
  logic             w_frame_start;

  assign w_tx_byte     = psx_tx_byte(r_byte_idx, r_btn);
  assign w_rx_next     = {w_cmd_lvl, r_rx[7:1]};
  assign w_rx_ok       = psx_rx_ok(r_byte_idx, w_rx_next);
  assign w_frame_start = w_att_fall & r_armed;

  // After reset the synchronizers start at 1, so a held-low att would look like a
  // fresh fall; only accept frame starts once att has genuinely been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else if (r_settle != 2'd3) begin
      r_settle <= r_settle + 2'd1;
    end else if (w_att_lvl) begin
      r_armed  <= 1'b1;
    end
  end

  // Button snapshot taken at frame start, held for the whole frame.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_frame_start) begin
      r_btn <= buttons;
    end
  end

  // Host command shift register, LSB first on each synced psx_clk rise.
  always_ff @(posedge clk) begin
    if (r_state == SHIFT && w_clk_rise) begin
      r_rx <= w_rx_next;
    end
  end

  // Frame state machine; an att rise overrides everything and returns to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_idx <= 3'd0;
      r_bit_cnt  <= 3'd0;
      r_cnt      <= '0;
      r_data     <= 1'b1;
      r_ack      <= 1'b1;
    end else if (w_att_rise) begin
      r_state    <= IDLE;
      r_byte_idx <= 3'd0;
      r_bit_cnt  <= 3'd0;
      r_cnt      <= '0;
      r_data     <= 1'b1;
      r_ack      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_data <= 1'b1;
          r_ack  <= 1'b1;
          if (w_frame_start) begin
            r_state    <= SHIFT;
            r_byte_idx <= 3'd0;
            r_bit_cnt  <= 3'd0;
          end
        end
        SHIFT: begin
          if (w_clk_fall) begin
            r_data <= w_tx_byte[r_bit_cnt];
          end
          if (w_clk_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (!w_rx_ok || r_byte_idx == LAST_IDX) begin
                r_state <= DONE;
                r_data  <= 1'b1;
              end else begin
                r_state <= ACK_WAIT;
                r_cnt   <= '0;
              end
            end
          end
        end
        ACK_WAIT: begin
          if (r_cnt == DLY_LAST) begin
            r_state <= ACK_PULSE;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ACK_PULSE: begin
          if (r_cnt == WID_LAST) begin
            r_state    <= SHIFT;
            r_ack      <= 1'b1;
            r_byte_idx <= r_byte_idx + 3'd1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_data <= 1'b1;
          r_ack  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data = r_data;
  assign ack  = r_ack;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: a host model clocks poll frames and a frame-level
// reference computes the expected reply bytes and acknowledge pulses.
module tb_psx_pad_responder;

  localparam int ACK_DELAY = 4;
  localparam int ACK_WIDTH = 8;
  localparam int GAP       = 3 + ACK_DELAY + ACK_WIDTH + 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic        att = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  logic        data;
  logic        ack;

  psx_pad_responder #(
    .ACK_DELAY (ACK_DELAY),
    .ACK_WIDTH (ACK_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .psx_clk (psx_clk),
    .cmd     (cmd),
    .att     (att),
    .buttons (buttons),
    .data    (data),
    .ack     (ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp  = 0;
  int nfail = 0;
  int hp    = 5;

  int   ack_falls[$];
  int   ack_widths[$];
  int   rise8[$];
  int   low_run = 0;
  logic ack_prev = 1'b1;

  logic [7:0] cmd_b[5];
  logic [7:0] rep_b[5];
  logic [7:0] exp_b[5];
  int         exp_nack;

  // Ack pulse monitor: start cycle and low length of every pulse.
  always @(posedge clk) begin
    #1;
    if (ack === 1'b0) begin
      if (ack_prev) ack_falls.push_back(cyc);
      low_run++;
    end else if (!ack_prev) begin
      ack_widths.push_back(low_run);
      low_run = 0;
    end
    ack_prev = (ack !== 1'b0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ack_falls.delete();
    ack_widths.delete();
    rise8.delete();
  endtask

  // Host side: one byte, LSB first; data sampled just before each rising edge.
  task automatic xfer_byte(input logic [7:0] c, input int nbits, output logic [7:0] r);
    r = 8'hFF;
    for (int b = 0; b < nbits; b++) begin
      psx_clk = 1'b0;
      cmd     = c[b];
      tick(hp);
      r[b]    = data;
      psx_clk = 1'b1;
      if (b == 7) rise8.push_back(cyc);
      tick(hp);
    end
  endtask

  // Reference: replies follow the fixed poll sequence until a bad header byte,
  // after which the pad goes silent (data high, no further acks).
  task automatic model_frame(input logic [15:0] btn);
    logic [7:0] tx[5];
    bit alive;
    tx[0] = 8'hFF; tx[1] = 8'h41; tx[2] = 8'h5A; tx[3] = btn[7:0]; tx[4] = btn[15:8];
    alive    = 1'b1;
    exp_nack = 0;
    for (int i = 0; i < 5; i++) begin
      exp_b[i] = alive ? tx[i] : 8'hFF;
      if (alive) begin
        if ((i == 0 && cmd_b[i] != 8'h01) || (i == 1 && cmd_b[i] != 8'h42)) alive = 1'b0;
        else if (i < 4) exp_nack++;
      end
    end
  endtask

  task automatic run_frame(input string nm, input logic [15:0] btn, input bit chg,
                           input logic [15:0] btn2);
    buttons = btn;
    model_frame(btn);
    clear_mon();
    att = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      xfer_byte(cmd_b[i], 8, rep_b[i]);
      if (chg && i == 0) buttons = btn2;
      tick(GAP);
    end
    att = 1'b1;
    tick(6);
    for (int i = 0; i < 5; i++) check($sformatf("%s_byte%0d", nm, i), rep_b[i], exp_b[i]);
    check({nm, "_nack"}, ack_falls.size(), exp_nack);
    check({nm, "_nwidth"}, ack_widths.size(), exp_nack);
    for (int i = 0; i < exp_nack && i < ack_falls.size() && i < ack_widths.size(); i++) begin
      check($sformatf("%s_ackw%0d", nm, i), ack_widths[i], ACK_WIDTH);
      check($sformatf("%s_ackdly%0d", nm, i), ack_falls[i] - rise8[i], 3 + ACK_DELAY);
    end
    check({nm, "_idle_data"}, data, 1'b1);
    check({nm, "_idle_ack"}, ack, 1'b1);
  endtask

  initial begin
    logic [7:0] r;
    int k;

    // Reset state, during and after reset.
    tick(3);
    check("rst_data", data, 1'b1);
    check("rst_ack", ack, 1'b1);
    rst = 1'b0;
    tick(8);
    check("post_rst_data", data, 1'b1);
    check("post_rst_ack", ack, 1'b1);

    // Canonical poll.
    hp = 5;
    cmd_b[0] = 8'h01; cmd_b[1] = 8'h42; cmd_b[2] = 8'h00; cmd_b[3] = 8'h00; cmd_b[4] = 8'h00;
    run_frame("full", 16'hFFFE, 1'b0, 16'h0);

    // Random polls: random buttons, don't-care bytes and clock phase lengths.
    for (int f = 0; f < 4; f++) begin
      hp = $urandom_range(4, 7);
      cmd_b[0] = 8'h01; cmd_b[1] = 8'h42;
      for (int i = 2; i < 5; i++) cmd_b[i] = 8'($urandom);
      run_frame($sformatf("rnd%0d", f), 16'($urandom), 1'b0, 16'h0);
    end

    // Bad first byte, then a good frame.
    hp = 4;
    cmd_b[0] = 8'h81; cmd_b[1] = 8'h42; cmd_b[2] = 8'h00; cmd_b[3] = 8'h00; cmd_b[4] = 8'h00;
    run_frame("bad0", 16'h1234, 1'b0, 16'h0);
    cmd_b[0] = 8'h01;
    run_frame("good_after_bad0", 16'hA55A, 1'b0, 16'h0);

    // Bad second byte.
    hp = 6;
    cmd_b[1] = 8'h43;
    run_frame("bad1", 16'h0F0F, 1'b0, 16'h0);

    // Random bad header byte.
    hp = 5;
    cmd_b[0] = 8'h01; cmd_b[1] = 8'h42;
    k = $urandom_range(0, 1);
    do cmd_b[k] = 8'($urandom); while (cmd_b[k] == (k == 0 ? 8'h01 : 8'h42));
    run_frame("badrnd", 16'($urandom), 1'b0, 16'h0);

    // att raised three bits into byte 2.
    hp = 5;
    clear_mon();
    att = 1'b0;
    tick(4);
    xfer_byte(8'h01, 8, r);
    check("abort_b0", r, 8'hFF);
    tick(GAP);
    xfer_byte(8'h42, 8, r);
    check("abort_b1", r, 8'h41);
    tick(GAP);
    xfer_byte(8'h00, 3, r);
    check("abort_b2_bits", r[2:0], 3'b010);
    check("abort_data_before", data, 1'b0);
    att = 1'b1;
    tick(4);
    check("abort_data_idle", data, 1'b1);
    check("abort_ack_idle", ack, 1'b1);
    tick(4);
    cmd_b[0] = 8'h01; cmd_b[1] = 8'h42; cmd_b[2] = 8'h00; cmd_b[3] = 8'h00; cmd_b[4] = 8'h00;
    run_frame("after_abort", 16'hC3C3, 1'b0, 16'h0);

    // Buttons change after the frame has started: snapshot must hold.
    run_frame("latch", 16'h0000, 1'b1, 16'hFFFF);

    // Reset in the middle of an ack pulse.
    hp = 5;
    clear_mon();
    att = 1'b0;
    tick(4);
    xfer_byte(8'h01, 8, r);
    k = 0;
    while (ack !== 1'b0 && k < 40) begin
      tick(1);
      k++;
    end
    check("rst_ack_pulse_seen", (k < 40), 1'b1);
    tick(2);
    rst = 1'b1;
    #1;
    check("rst_async_ack", ack, 1'b1);
    check("rst_async_data", data, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(6);
    clear_mon();
    xfer_byte(8'h01, 8, r);
    check("rst_silent_data", r, 8'hFF);
    tick(GAP);
    xfer_byte(8'h42, 8, r);
    check("rst_silent_data2", r, 8'hFF);
    tick(GAP);
    check("rst_silent_nack", ack_falls.size(), 0);
    att = 1'b1;
    tick(6);
    run_frame("after_rst", 16'($urandom), 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
